// File: rtl/carregador_de_instrucoes_pkg.sv
// Shared loader constants and FSM state encoding.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package carregador_de_instrucoes_pkg;

  localparam int LARG_CABECALHO    = 16;
  localparam int BYTES_POR_PALAVRA = 4;
  localparam logic [1:0] ULTIMO_BYTE =
    2'(BYTES_POR_PALAVRA - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CAB_HI  = 3'd1,
    CAB_LO  = 3'd2,
    DADOS   = 3'd3,
    ESCRITA = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    CHECK   = 3'd5,
`endif
    FIM     = 3'd6
  } estado_t;

endpackage

// File: rtl/carregador_de_instrucoes_montador_de_palavra.sv
// 8->32 big-endian word assembler: first byte ends up in [31:24].
// cheio marks a complete word until the write consumes it.
import carregador_de_instrucoes_pkg::*;

module montador_de_palavra (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_limpa,
  input  logic        i_desloca,
  input  logic        i_consome,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_palavra,
  output logic [1:0]  o_indice,
  output logic        o_cheio
);

  logic [31:0] r_palavra;
  logic [1:0]  r_indice;
  logic        r_cheio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_palavra <= '0;
      r_indice  <= '0;
      r_cheio   <= 1'b0;
    end else if (i_limpa) begin
      r_indice <= '0;
      r_cheio  <= 1'b0;
    end else if (i_desloca) begin
      r_palavra <= {r_palavra[23:0], i_byte};
      r_indice  <= r_indice + 2'd1;
      r_cheio   <= (r_indice == ULTIMO_BYTE);
    end else if (i_consome) begin
      r_cheio <= 1'b0;
    end
  end

  assign o_palavra = r_palavra;
  assign o_indice  = r_indice;
  assign o_cheio   = r_cheio;

endmodule

// File: rtl/carregador_de_instrucoes.sv
// Byte-stream program loader for instruction memory; halts the CPU while loading.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
import carregador_de_instrucoes_pkg::*;

module carregador_de_instrucoes #(
  parameter int RAM_SIZE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        cpu_halt,
  output logic        done,
  output logic        erro,
  output logic [15:0] word_count
);

  estado_t r_estado;
  estado_t w_prox;
  estado_t w_pos_dados;

  logic [7:0]                r_hi;
  logic [LARG_CABECALHO-1:0] r_n;
  logic [15:0]               r_wc;
  logic                      r_done;
  logic                      r_erro;

  logic                      w_hs;
  logic                      w_inicia;
  logic [LARG_CABECALHO-1:0] w_n;
  logic                      w_excede;
  logic                      w_ultima;
  logic [31:0]               w_palavra;
  logic [1:0]                w_indice;
  logic                      w_cheio;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  assign w_pos_dados = CHECK;
`else
  assign w_pos_dados = FIM;
`endif

  assign w_hs     = byte_valid && byte_ready;
  assign w_inicia = (r_estado == OCIOSO) && start;
  assign w_n      = {r_hi, byte_in};
  assign w_excede = {16'd0, w_n} > 32'(RAM_SIZE);
  assign w_ultima = (r_wc + 16'd1) == r_n;

  montador_de_palavra u_montador (
    .clk       (clk),
    .rst       (rst),
    .i_limpa   (w_inicia),
    .i_desloca (w_hs && (r_estado == DADOS)),
    .i_consome (r_estado == ESCRITA),
    .i_byte    (byte_in),
    .o_palavra (w_palavra),
    .o_indice  (w_indice),
    .o_cheio   (w_cheio)
  );

  always_ff @(posedge clk) begin
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox;
  end

  always_comb begin
    w_prox     = r_estado;
    byte_ready = 1'b0;
    we         = 1'b0;
    case (r_estado)
      OCIOSO: if (start) w_prox = CAB_HI;
      CAB_HI: begin
        byte_ready = 1'b1;
        if (w_hs) w_prox = CAB_LO;
      end
      CAB_LO: begin
        byte_ready = 1'b1;
        if (w_hs) begin
          if (w_excede)        w_prox = FIM;
          else if (w_n == '0)  w_prox = w_pos_dados;
          else                 w_prox = DADOS;
        end
      end
      DADOS: begin
        byte_ready = 1'b1;
        if (w_hs && (w_indice == ULTIMO_BYTE))
          w_prox = ESCRITA;
      end
      ESCRITA: begin
        we     = w_cheio;
        w_prox = w_ultima ? w_pos_dados : DADOS;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (w_hs) w_prox = FIM;
      end
`endif
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_n    <= '0;
      r_wc   <= '0;
      r_done <= 1'b0;
      r_erro <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      if (w_inicia) begin
        r_wc   <= '0;
        r_done <= 1'b0;
        r_erro <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_csum <= '0;
`endif
      end
      if (w_hs && (r_estado == CAB_HI))
        r_hi <= byte_in;
      if (w_hs && (r_estado == CAB_LO)) begin
        r_n <= w_n;
        if (w_excede) r_erro <= 1'b1;
      end
      if (r_estado == ESCRITA)
        r_wc <= r_wc + 16'd1;
      if (w_prox == FIM)
        r_done <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (w_hs && (r_estado == DADOS))
        r_csum <= r_csum ^ byte_in;
      if (w_hs && (r_estado == CHECK) && (byte_in != r_csum))
        r_erro <= 1'b1;
`endif
    end
  end

  assign addr       = {16'd0, r_wc};
  assign datain     = w_palavra;
  assign cpu_halt   = (r_estado != OCIOSO);
  assign done       = r_done;
  assign erro       = r_erro;
  assign word_count = r_wc;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Directed-vector bench for carregador_de_instrucoes.
// Follows LOADER_CHECKSUM_EN to match the DUT build.
module tb_carregador_de_instrucoes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        cpu_halt;
  logic        done;
  logic        erro;
  logic [15:0] word_count;

  int n_vec = 0;
  int n_err = 0;
  int n_we  = 0;

  carregador_de_instrucoes #(.RAM_SIZE(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .we         (we),
    .addr       (addr),
    .datain     (datain),
    .cpu_halt   (cpu_halt),
    .done       (done),
    .erro       (erro),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) n_we++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  task automatic envia(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic envia_lento(input logic [7:0] b);
    byte_valid = 1'b0;
    byte_in    = b;
    passo();
    envia(b);
  endtask

  task automatic inicia();
    start = 1'b1;
    passo();
    start = 1'b0;
  endtask

  task automatic fecha(input logic [7:0] csum);
    passo();
`ifdef LOADER_CHECKSUM_EN
    envia(csum);
`else
    if (csum === 8'hxx) passo();
`endif
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(we),         32'd0);
    chk({tag, "_addr"},  addr,            32'd0);
    chk({tag, "_data"},  datain,          32'd0);
    chk({tag, "_halt"},  32'(cpu_halt),   32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_erro"},  32'(erro),       32'd0);
    chk({tag, "_wc"},    32'(word_count), 32'd0);
  endtask

  initial begin
    int we0;
    int acc;
    repeat (2) passo();
    rst = 1'b0;
    zeros("reset");

    // basic two-word load
    inicia();
    chk("basic_halt", 32'(cpu_halt), 32'd1);
    envia(8'h00); envia(8'h02);
    envia(8'h12); envia(8'h34); envia(8'h56); envia(8'h78);
    chk("w0_we",   32'(we), 32'd1);
    chk("w0_addr", addr,    32'd0);
    chk("w0_data", datain,  32'h1234_5678);
    envia(8'h9A); envia(8'hBC); envia(8'hDE); envia(8'hF0);
    chk("w1_we",   32'(we), 32'd1);
    chk("w1_addr", addr,    32'd1);
    chk("w1_data", datain,  32'h9ABC_DEF0);
    fecha(8'h00);
    chk("basic_done", 32'(done),       32'd1);
    chk("basic_erro", 32'(erro),       32'd0);
    chk("basic_wc",   32'(word_count), 32'd2);
    passo();
    chk("basic_rel",  32'(cpu_halt),   32'd0);
    chk("basic_nwe",  32'(n_we),       32'd2);

    // empty load
    we0 = n_we;
    inicia();
    chk("empty_clr", 32'(done), 32'd0);
    envia(8'h00); envia(8'h00);
`ifdef LOADER_CHECKSUM_EN
    chk("empty_ck_done", 32'(done), 32'd0);
    envia(8'h00);
`endif
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_erro", 32'(erro), 32'd0);
    chk("empty_nwe",  32'(n_we - we0), 32'd0);

    // oversized header rejected
    passo();
    inicia();
    envia(8'h00); envia(8'h65);
    chk("big_erro", 32'(erro), 32'd1);
    chk("big_done", 32'(done), 32'd1);
    acc = 0;
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (byte_ready) acc++;
    end
    byte_valid = 1'b0;
    passo();
    chk("big_noacc", 32'(acc), 32'd0);
    chk("big_nwe",   32'(n_we - we0), 32'd0);
    chk("big_wc",    32'(word_count), 32'd0);

    // stalled source, one word
    inicia();
    envia_lento(8'h00); envia_lento(8'h01);
    envia_lento(8'hCA); envia_lento(8'hFE);
    envia_lento(8'hBA);
    chk("stall_nowe", 32'(we), 32'd0);
    envia_lento(8'hBE);
    chk("stall_we",   32'(we), 32'd1);
    chk("stall_addr", addr,    32'd0);
    chk("stall_data", datain,  32'hCAFE_BABE);
    fecha(8'h30);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_erro", 32'(erro), 32'd0);
    chk("stall_nwe",  32'(n_we - we0), 32'd1);

    // reset mid-load
    passo();
    we0 = n_we;
    inicia();
    envia(8'h00); envia(8'h01);
    envia(8'h11); envia(8'h22);
    rst = 1'b1;
    passo();
    zeros("mrst");
    rst = 1'b0;
    repeat (2) passo();
    chk("mrst_nwe", 32'(n_we - we0), 32'd0);

    // reload after reset, good checksum 0x0F
    inicia();
    envia(8'h00); envia(8'h01);
    envia(8'h01); envia(8'h02); envia(8'h04); envia(8'h08);
    chk("rl_we",   32'(we), 32'd1);
    chk("rl_addr", addr,    32'd0);
    chk("rl_data", datain,  32'h0102_0408);
    fecha(8'h0F);
    chk("rl_done", 32'(done), 32'd1);
    chk("rl_erro", 32'(erro), 32'd0);
    chk("rl_wc",   32'(word_count), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum 0x0E
    passo();
    inicia();
    envia(8'h00); envia(8'h01);
    envia(8'h01); envia(8'h02); envia(8'h04); envia(8'h08);
    fecha(8'h0E);
    chk("ck_done", 32'(done), 32'd1);
    chk("ck_erro", 32'(erro), 32'd1);
`endif

    repeat (2) passo();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
